mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline. Consumes the execute→memory pipeline register outputs (op, ALU result, store data, destination registers).
- Performs the data-memory access for LW/SW over a req/ack handshake with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers results into the memory→writeback pipeline register (W_* outputs).

Parameters:
- OP_LW, 6'b100011, load-word opcode
- OP_SW, 6'b101011, store-word opcode
- OP_NOP, 6'b000000, op value inserted as a bubble
- TIMEOUT, 16, max cycles waiting for dm_ack before abort (≥2)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- M_op  in  6  opcode of instruction in memory stage
- M_valE  in  32  ALU result; byte address for LW/SW, passthrough otherwise
- M_valA  in  32  store data for SW
- M_dstE  in  5  ALU-result destination register
- M_dstM  in  5  load destination register
- dm_ack  in  1  data memory completes the access this cycle
- dm_rdata  in  32  load data; valid when dm_ack=1 on a read
- dm_req  out  1  access request (combinational)
- dm_we  out  1  1=write (SW), 0=read (LW)
- dm_addr  out  32  equals M_valE
- dm_wdata  out  32  equals M_valA
- m_stall  out  1  hold F/D/E/M registers this cycle (combinational)
- m_err  out  1  sticky error: misaligned access or timeout
- W_op  out  6  registered op to writeback
- W_valE  out  32  registered ALU result
- W_valM  out  32  registered load data
- W_dstE  out  5  registered ALU destination
- W_dstM  out  5  registered load destination

Behaviour:
- Reset (rst_n=0, async):
  - FSM→IDLE, wait counter=0, m_err=0.
  - All W_* = 0 (W_op=OP_NOP).
  - dm_req, m_stall forced 0 while rst_n=0.
- mem_op = (M_op==OP_LW || M_op==OP_SW) && M_valE[1:0]==2'b00.
- misaligned = (LW/SW) && M_valE[1:0]!=0:
  - No request is issued; m_err set next edge.
  - W gets a bubble; m_stall=0.
- FSM states: IDLE, WAIT.
  - IDLE, mem_op:
    - dm_req=1, dm_we=(M_op==OP_SW).
    - If dm_ack: complete this cycle, stay IDLE.
    - Else: m_stall=1, go to WAIT, counter=1.
  - WAIT:
    - dm_req=1; addr/wdata/we held stable, because upstream is stalled and M_* stay constant.
    - If dm_ack: complete, go to IDLE, counter=0.
    - Else if counter==TIMEOUT-1: abort. dm_req stays 1 this cycle, m_stall=0, W gets a bubble, m_err←1, go to IDLE.
    - Else: counter+1, m_stall=1.
- Completion cycle: m_stall=0. At the edge, W_op=M_op, W_valE=M_valE, W_dstE=M_dstE, W_dstM=M_dstM. W_valM=dm_rdata for LW; W_valM=0 for SW.
- Non-memory op in IDLE:
  - dm_req=0, m_stall=0, no stall.
  - W_* ← M_* with W_valM=0.
  - dm_ack in this cycle is ignored.
- Stalled cycle (m_stall=1): W loads a bubble: W_op=OP_NOP, dstE=dstM=0, valE=valM=0.
- Latency: M→W is 1 cycle with zero-wait memory; N+1 cycles when dm_ack arrives N cycles after first request.
- Back-to-back LW/SW with zero-wait memory: one access per cycle, no stalls.
- dm_req never asserts two consecutive cycles for the same instruction after completion.
- m_err clears only on reset.

Test Plan:
- Zero-wait load: M_op=LW, M_valE=0x100, dm_ack same cycle, dm_rdata=0xDEADBEEF, M_dstM=5 → dm_req=1, dm_we=0, m_stall=0; next edge W_op=LW, W_valM=0xDEADBEEF, W_dstM=5.
- Wait-state store: M_op=SW, M_valE=0x200, M_valA=0x12345678, ack after 3 cycles → m_stall=1 for 3 cycles; dm_addr/dm_wdata/dm_we=1 stable throughout; W_op=NOP during the stall; W_op=SW after the ack edge.
- ALU op passthrough: M_op=6'b000000 (R-type), M_valE=0x7, M_dstE=9 → dm_req=0, m_stall=0, W_valE=0x7, W_dstE=9, W_valM=0.
- Misaligned: LW with M_valE=0x102 → dm_req=0, m_stall=0, W_op=NOP, m_err=1 and sticky.
- Timeout: LW, dm_ack held 0 → m_stall=1 for TIMEOUT-1 cycles (15), abort on cycle 16, m_err=1, FSM IDLE; the next LW with immediate ack completes normally.
- Reset mid-WAIT: rst_n low during cycle 2 of a pending LW → dm_req, m_stall drop immediately; W_*=0; after release, FSM IDLE and the held LW re-issues.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
// Issues LW/SW accesses over a req/ack handshake with variable latency,
// stalls upstream while an access is pending, aborts on timeout, and
// registers the result into the memory->writeback pipeline register.
module mem_stage #(
  parameter logic [5:0]  OP_LW   = 6'b100011,
  parameter logic [5:0]  OP_SW   = 6'b101011,
  parameter logic [5:0]  OP_NOP  = 6'b000000,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  M_op,
  input  logic [31:0] M_valE,
  input  logic [31:0] M_valA,
  input  logic [4:0]  M_dstE,
  input  logic [4:0]  M_dstM,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        m_stall,
  output logic        m_err,
  output logic [5:0]  W_op,
  output logic [31:0] W_valE,
  output logic [31:0] W_valM,
  output logic [4:0]  W_dstE,
  output logic [4:0]  W_dstM
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic is_ls;
  logic misaligned;
  logic mem_op;
  logic timeout_hit;
  logic complete;
  logic load_w;

  // Decode the access, handshake outputs and stall/abort conditions.
  always_comb begin
    is_ls       = (M_op == OP_LW) || (M_op == OP_SW);
    misaligned  = is_ls && (M_valE[1:0] != 2'b00);
    mem_op      = is_ls && (M_valE[1:0] == 2'b00);
    dm_req      = rst_n && ((state == S_WAIT) || ((state == S_IDLE) && mem_op));
    dm_we       = (M_op == OP_SW);
    dm_addr     = M_valE;
    dm_wdata    = M_valA;
    timeout_hit = (state == S_WAIT) && !dm_ack && (cnt == CW'(TIMEOUT - 1));
    m_stall     = dm_req && !dm_ack && !timeout_hit;
    complete    = dm_req && dm_ack;
    // W captures M on a completed access or a non-memory op in IDLE;
    // every other cycle (stall, misaligned, timeout) inserts a bubble.
    load_w      = complete || ((state == S_IDLE) && !is_ls);
  end

  // Access FSM with wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op && !dm_ack) begin
            state <= S_WAIT;
            cnt   <= CW'(1);
          end
        end
        S_WAIT: begin
          if (dm_ack || timeout_hit) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky error flag: misaligned access or handshake timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err <= 1'b0;
    end else if ((misaligned && (state == S_IDLE)) || timeout_hit) begin
      m_err <= 1'b1;
    end
  end

  // Memory->writeback pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_op   <= OP_NOP;
      W_valE <= '0;
      W_valM <= '0;
      W_dstE <= '0;
      W_dstM <= '0;
    end else if (load_w) begin
      W_op   <= M_op;
      W_valE <= M_valE;
      W_valM <= (complete && (M_op == OP_LW)) ? dm_rdata : '0;
      W_dstE <= M_dstE;
      W_dstM <= M_dstM;
    end else begin
      W_op   <= OP_NOP;
      W_valE <= '0;
      W_valM <= '0;
      W_dstE <= '0;
      W_dstM <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. A driver issues instructions
// and plays the data memory with a chosen latency; expected writeback tuples
// are queued at issue and popped by an independent monitor.
module tb_mem_stage;

  localparam logic [5:0]  OP_LW  = 6'b100011;
  localparam logic [5:0]  OP_SW  = 6'b101011;
  localparam logic [5:0]  OP_NOP = 6'b000000;
  localparam int unsigned TO     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  M_op;
  logic [31:0] M_valE, M_valA;
  logic [4:0]  M_dstE, M_dstM;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_req, dm_we, m_stall, m_err;
  logic [31:0] dm_addr, dm_wdata;
  logic [5:0]  W_op;
  logic [31:0] W_valE, W_valM;
  logic [4:0]  W_dstE, W_dstM;

  mem_stage #(.OP_LW(OP_LW), .OP_SW(OP_SW), .OP_NOP(OP_NOP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .m_stall(m_stall), .m_err(m_err), .W_op(W_op), .W_valE(W_valE),
    .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] ve;
    logic [31:0] vm;
    logic [4:0]  de;
    logic [4:0]  dm;
  } wres_t;

  wres_t       sbq[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        exp_err = 1'b0;
  logic        mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // One instruction: lat = cycles after first request until dm_ack (>=TO: never).
  task automatic do_instr(input logic [5:0] op, input logic [31:0] ve, input logic [31:0] va,
                          input logic [4:0] de, input logic [4:0] dm, input int lat);
    logic  ls, mis, memop, exp_stall;
    wres_t e;
    logic [31:0] ld;
    ls    = (op == OP_LW) || (op == OP_SW);
    mis   = ls && (ve[1:0] != 2'b00);
    memop = ls && !mis;
    ld    = rd_model(ve);
    e     = '{op: op, ve: ve, vm: 32'h0, de: de, dm: dm};
    if (!ls) begin
      if (e != '0) sbq.push_back(e);
    end else if (memop && lat < int'(TO)) begin
      if (op == OP_LW) e.vm = ld;
      else mem[ve] = va;
      sbq.push_back(e);
    end
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      M_op = op; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
      dm_ack   = memop ? (k == lat) : 1'($urandom_range(0, 1));
      dm_rdata = (memop && op == OP_LW && k == lat) ? ld : $urandom;
      #1;
      chk("dm_req", {31'h0, dm_req}, {31'h0, memop});
      if (memop) begin
        chk("dm_we", {31'h0, dm_we}, {31'h0, op == OP_SW});
        chk("dm_addr", dm_addr, ve);
        chk("dm_wdata", dm_wdata, va);
      end
      exp_stall = memop && (k < lat) && (k < int'(TO) - 1);
      chk("m_stall", {31'h0, m_stall}, {31'h0, exp_stall});
      @(posedge clk);
      if (mis || (memop && k == int'(TO) - 1 && lat > k)) exp_err = 1'b1;
      if (exp_stall) begin
        #1;
        chk("stall_bubble_op", {26'h0, W_op}, {26'h0, OP_NOP});
        chk("stall_bubble_valE", W_valE, 32'h0);
      end
      if (!memop || k >= lat || k == int'(TO) - 1) break;
    end
  endtask

  // Monitor: pops the scoreboard whenever W presents a non-bubble result.
  initial begin
    wres_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        chk("m_err", {31'h0, m_err}, {31'h0, exp_err});
        if ({W_op, W_valE, W_valM, W_dstE, W_dstM} != '0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_W_op", {26'h0, W_op}, {26'h0, OP_NOP});
          end else begin
            e = sbq.pop_front();
            chk("W_op", {26'h0, W_op}, {26'h0, e.op});
            chk("W_valE", W_valE, e.ve);
            chk("W_valM", W_valM, e.vm);
            chk("W_dstE", {27'h0, W_dstE}, {27'h0, e.de});
            chk("W_dstM", {27'h0, W_dstM}, {27'h0, e.dm});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] alu_ops [4];
    alu_ops = '{6'h00, 6'h08, 6'h0d, 6'h0f};
    rst_n = 1'b0; M_op = OP_LW; M_valE = 32'h40; M_valA = '0; M_dstE = '0; M_dstM = '0;
    dm_ack = 1'b0; dm_rdata = '0;
    #3;
    chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst_m_stall", {31'h0, m_stall}, 32'h0);
    chk("rst_W_op", {26'h0, W_op}, {26'h0, OP_NOP});
    chk("rst_W_valE", W_valE, 32'h0);
    chk("rst_W_valM", W_valM, 32'h0);
    chk("rst_m_err", {31'h0, m_err}, 32'h0);
    @(negedge clk);
    M_op = OP_NOP; M_valE = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed cases
    mem[32'h100] = 32'hDEADBEEF;
    do_instr(OP_LW, 32'h100, 32'h0, 5'd0, 5'd5, 0);
    do_instr(OP_SW, 32'h200, 32'h12345678, 5'd0, 5'd0, 3);
    do_instr(6'h00, 32'h7, 32'h0, 5'd9, 5'd0, 0);
    do_instr(OP_LW, 32'h102, 32'h0, 5'd0, 5'd4, 0);
    do_instr(6'h08, 32'h55, 32'h0, 5'd2, 5'd0, 0);
    do_instr(OP_LW, 32'h200, 32'h0, 5'd0, 5'd6, 100);
    do_instr(OP_LW, 32'h200, 32'h0, 5'd0, 5'd6, 0);
    do_instr(OP_SW, 32'h300, 32'hCAFEF00D, 5'd1, 5'd2, int'(TO) - 1);

    // Reset while a load is waiting
    @(negedge clk);
    M_op = OP_LW; M_valE = 32'h40; M_valA = '0; M_dstE = 5'd3; M_dstM = 5'd7; dm_ack = 1'b0;
    #1 chk("rw_req_c1", {31'h0, dm_req}, 32'h1);
    @(negedge clk);
    #1 chk("rw_stall_c2", {31'h0, m_stall}, 32'h1);
    rst_n = 1'b0; exp_err = 1'b0;
    #1;
    chk("rw_dm_req", {31'h0, dm_req}, 32'h0);
    chk("rw_m_stall", {31'h0, m_stall}, 32'h0);
    chk("rw_W_op", {26'h0, W_op}, {26'h0, OP_NOP});
    chk("rw_W_dstM", {27'h0, W_dstM}, 32'h0);
    chk("rw_m_err", {31'h0, m_err}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_instr(OP_LW, 32'h40, 32'h0, 5'd3, 5'd7, 1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int unsigned r, lr;
      int          lat;
      logic [5:0]  op;
      logic [31:0] a;
      r  = $urandom_range(0, 99);
      lr = $urandom_range(0, 99);
      a  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      if (lr < 50)      lat = 0;
      else if (lr < 80) lat = int'($urandom_range(1, 4));
      else if (lr < 92) lat = int'($urandom_range(5, TO - 1));
      else              lat = 100;
      if (r < 35)      op = OP_LW;
      else if (r < 65) op = OP_SW;
      else if (r < 92) op = alu_ops[$urandom_range(0, 3)];
      else begin
        op = (r[0]) ? OP_LW : OP_SW;
        a  = a | 32'($urandom_range(1, 3));
      end
      do_instr(op, a, $urandom, 5'($urandom), 5'($urandom), lat);
    end

    @(negedge clk);
    M_op = OP_NOP; M_valE = '0; M_valA = '0; M_dstE = '0; M_dstM = '0; dm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
